// File: rtl/apb_regspace_bridge_if.sv
// rtl/apb_regspace_bridge_if.sv - APB slave bus plus register-space read/write handshakes
interface apb_regspace_bridge_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) ();
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;
  logic [ADDR_W-1:0] rreq_addr;
  logic              rreq_vld;
  logic              rreq_rdy;
  logic [DATA_W-1:0] rack_data;
  logic              rack_vld;
  logic              rack_rdy;
  logic [ADDR_W-1:0] wreq_addr;
  logic [DATA_W-1:0] wreq_data;
  logic              wreq_vld;
  logic              wreq_rdy;

  // Bridge side: APB slave upstream, request initiator downstream
  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr,
    output rreq_addr, rreq_vld, rack_rdy,
    input  rreq_rdy, rack_data, rack_vld,
    output wreq_addr, wreq_data, wreq_vld,
    input  wreq_rdy
  );

  // Surrounding side: APB master plus register-space responder
  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr,
    input  rreq_addr, rreq_vld, rack_rdy,
    output rreq_rdy, rack_data, rack_vld,
    input  wreq_addr, wreq_data, wreq_vld,
    output wreq_rdy
  );
endinterface

// File: rtl/apb_regspace_bridge.sv
// rtl/apb_regspace_bridge.sv - APB3 slave to register-space rreq/rack and wreq bridge
module apb_regspace_bridge #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  apb_regspace_bridge_if.slave   bus
);

  localparam int            CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] rreq_addr_q, rreq_addr_d;
  logic [ADDR_W-1:0] wreq_addr_q, wreq_addr_d;
  logic [DATA_W-1:0] wreq_data_q, wreq_data_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              err_d;
  logic              pready_q, pslverr_q;
  logic              rreq_vld_q, rack_rdy_q, wreq_vld_q;
  logic [CW-1:0]     cnt_inc;
  logic              timed_out;

  // Next-state logic: latch the setup phase, wait for the downstream handshake or timeout
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rreq_addr_d = rreq_addr_q;
    wreq_addr_d = wreq_addr_q;
    wreq_data_d = wreq_data_q;
    prdata_d    = '0;
    err_d       = 1'b0;
    // Saturating increment; completion in the timeout cycle still wins below
    cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    timed_out   = (TIMEOUT != 0) && (cnt_inc == TO_VAL);

    unique case (state_q)
      IDLE: begin
        if (bus.psel && !bus.penable) begin
          cnt_d = '0;
          if (bus.pwrite) begin
            wreq_addr_d = bus.paddr;
            wreq_data_d = bus.pwdata;
          end else begin
            rreq_addr_d = bus.paddr;
          end
          if (bus.paddr[1:0] != 2'b00) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else if (bus.pwrite) begin
            state_d = WR_WAIT;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (rreq_vld_q && bus.rreq_rdy && bus.rack_vld) begin
          prdata_d = bus.rack_data;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_inc;
          if (timed_out) begin
            state_d = RESP;
            err_d   = 1'b1;
          end
        end
      end
      WR_WAIT: begin
        if (wreq_vld_q && bus.wreq_rdy) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_inc;
          if (timed_out) begin
            state_d = RESP;
            err_d   = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; outputs decode the upcoming state so they change with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rreq_addr_q <= '0;
      wreq_addr_q <= '0;
      wreq_data_q <= '0;
      prdata_q    <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      rreq_vld_q  <= 1'b0;
      rack_rdy_q  <= 1'b0;
      wreq_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rreq_addr_q <= rreq_addr_d;
      wreq_addr_q <= wreq_addr_d;
      wreq_data_q <= wreq_data_d;
      prdata_q    <= prdata_d;
      pready_q    <= (state_d == RESP);
      pslverr_q   <= (state_d == RESP) && err_d;
      rreq_vld_q  <= (state_d == RD_WAIT);
      rack_rdy_q  <= (state_d == RD_WAIT);
      wreq_vld_q  <= (state_d == WR_WAIT);
    end
  end

  assign bus.pready    = pready_q;
  assign bus.prdata    = prdata_q;
  assign bus.pslverr   = pslverr_q;
  assign bus.rreq_addr = rreq_addr_q;
  assign bus.rreq_vld  = rreq_vld_q;
  assign bus.rack_rdy  = rack_rdy_q;
  assign bus.wreq_addr = wreq_addr_q;
  assign bus.wreq_data = wreq_data_q;
  assign bus.wreq_vld  = wreq_vld_q;

endmodule

// File: tb/tb_apb_regspace_bridge.sv
// tb/tb_apb_regspace_bridge.sv - scoreboard bench for apb_regspace_bridge
module tb_apb_regspace_bridge;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_regspace_bridge_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  apb_regspace_bridge #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] prdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];

  // Current transaction as seen by the downstream responder
  logic [15:0] cur_addr = '0;
  logic [31:0] cur_wdata = '0;
  logic [31:0] cur_rdata = '0;
  logic        cur_write = 1'b0;
  logic        cur_mis = 1'b0;
  int          cur_dly = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every pready cycle pops the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.pready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_pready", 32'(bus.pready), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("prdata", bus.prdata, e.prdata);
          chk("pslverr", 32'(bus.pslverr), 32'(e.err));
          chk("pready_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else begin
        chk("pslverr_idle", 32'(bus.pslverr), 32'd0);
      end
    end
  end

  // Responder: holds off ready for cur_dly valid cycles, then accepts
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      bus.rreq_rdy  = 1'b0;
      bus.rack_vld  = 1'b0;
      bus.wreq_rdy  = 1'b0;
      bus.rack_data = $urandom;
      if (rst_n && (bus.rreq_vld || bus.wreq_vld)) begin
        chk("no_req_when_misaligned", 32'(cur_mis), 32'd0);
        chk("req_kind", 32'(bus.wreq_vld), 32'(cur_write));
        if (bus.rreq_vld) begin
          chk("rack_rdy", 32'(bus.rack_rdy), 32'd1);
          chk("rreq_addr", 32'(bus.rreq_addr), 32'(cur_addr));
        end else begin
          chk("wreq_addr", 32'(bus.wreq_addr), 32'(cur_addr));
          chk("wreq_data", bus.wreq_data, cur_wdata);
        end
        if (cnt == cur_dly) begin
          bus.rreq_rdy  = bus.rreq_vld;
          bus.rack_vld  = bus.rreq_vld;
          bus.rack_data = cur_rdata;
          bus.wreq_rdy  = bus.wreq_vld;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic do_txn(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int dly, input bit viol, input bit hold);
    exp_t e;
    bit   mis;
    bit   got;
    @(posedge clk);
    #1;
    mis = (addr % 4) != 0;
    e.err = mis || (dly >= TO);
    e.prdata = (wr || e.err) ? 32'd0 : rd;
    e.cyc = cyc + 1 + (mis ? 0 : (e.err ? TO : dly + 1));
    exp_q.push_back(e);
    cur_addr = addr; cur_wdata = wd; cur_rdata = rd;
    cur_write = wr; cur_mis = mis; cur_dly = dly;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
    bus.paddr = addr; bus.pwdata = wd;
    @(posedge clk);
    #1;
    bus.penable = 1'b1;
    if (viol) begin
      bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = ~wr;
      bus.paddr = 16'($urandom); bus.pwdata = $urandom;
    end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = bus.pready;
    end
    if (!got) chk("pready_timeout", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    if (hold) begin
      bus.psel = 1'b1; bus.penable = 1'b1;
      repeat (2) @(posedge clk);
      #1;
    end
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  initial begin
    logic [15:0] a;
    bit          mis;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0;
    bus.rreq_rdy = 1'b0; bus.rack_vld = 1'b0; bus.rack_data = '0; bus.wreq_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pready", 32'(bus.pready), 32'd0);
    chk("rst_prdata", bus.prdata, 32'd0);
    chk("rst_rreq_vld", 32'(bus.rreq_vld), 32'd0);
    chk("rst_wreq_vld", 32'(bus.wreq_vld), 32'd0);
    chk("rst_rack_rdy", 32'(bus.rack_rdy), 32'd0);
    rst_n = 1'b1;

    do_txn(1'b0, 16'h0000, 32'h0, 32'hA500_0000, 0, 1'b0, 1'b0);
    do_txn(1'b1, 16'h0020, 32'h0000_0075, 32'h0, 0, 1'b0, 1'b0);
    do_txn(1'b0, 16'h0104, 32'h0, 32'h1234_5678, 5, 1'b0, 1'b0);
    do_txn(1'b1, 16'h0040, 32'hDEAD_BEEF, 32'h0, 20, 1'b0, 1'b0);
    do_txn(1'b0, 16'h0002, 32'h0, 32'h5555_AAAA, 0, 1'b0, 1'b0);
    do_txn(1'b0, 16'h0048, 32'h0, 32'hCAFE_F00D, TO - 1, 1'b0, 1'b0);
    do_txn(1'b0, 16'h004C, 32'h0, 32'hCAFE_F00D, TO, 1'b0, 1'b0);
    do_txn(1'b1, 16'h0050, 32'h0BAD_CAFE, 32'h0, TO - 1, 1'b1, 1'b1);

    for (int n = 0; n < 40; n++) begin
      mis = ($urandom_range(0, 5) == 0);
      a = 16'($urandom) & 16'hFFFC;
      if (mis) a = a | 16'($urandom_range(1, 3));
      do_txn(1'($urandom_range(0, 1)), a, $urandom, $urandom, $urandom_range(0, 10),
             $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
    end

    // Reset in the middle of a read wait: request drops immediately, access is lost
    @(posedge clk);
    #1;
    cur_addr = 16'h0060; cur_write = 1'b0; cur_mis = 1'b0; cur_dly = 100;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 16'h0060;
    @(posedge clk);
    #1;
    bus.penable = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_rreq_vld", 32'(bus.rreq_vld), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rreq_vld", 32'(bus.rreq_vld), 32'd0);
    chk("async_rst_rack_rdy", 32'(bus.rack_rdy), 32'd0);
    bus.psel = 1'b0; bus.penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(1'b0, 16'h0064, 32'h0, 32'h0F0F_1234, 1, 1'b0, 1'b0);
    do_txn(1'b1, 16'h0068, 32'h7777_0001, 32'h0, 3, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
